// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: state encoding and default width.
package serial_adder_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int unsigned SA_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_DONE = ST_DONE
  } sa_state_e;

endpackage

// File: rtl/serial_adder_ctrl_full_adder.sv
// One-bit full adder cell used by the serial adder for the per-bit add.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  // Sum and carry of a single bit position.
  always_comb begin
    s    = a ^ b ^ cin;
    cout = (a & b) | (cin & (a ^ b));
  end

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: latches two WIDTH-bit operands plus carry-in on
// an accepted start, adds one bit pair per clock (LSB first) through a single
// full_adder cell, then presents {cout, sum} with a one-cycle done pulse.
// Optional macro SERIAL_ADDER_OVF_EN adds a registered signed-overflow output ovf.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter  int unsigned WIDTH = SA_WIDTH_DEF,
  localparam int unsigned CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  sa_state_e        state_q,  state_d;
  logic [WIDTH-1:0] a_sh_q,   a_sh_d;
  logic [WIDTH-1:0] b_sh_q,   b_sh_d;
  logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
  logic             carry_q,  carry_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic             busy_q,   busy_d;
  logic             done_q,   done_d;
  logic [WIDTH-1:0] sum_q,    sum_d;
  logic             cout_q,   cout_d;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf_q,    ovf_d;
`endif

  logic fa_s;
  logic fa_co;

  full_adder u_fa (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .cin  (carry_q),
    .s    (fa_s),
    .cout (fa_co)
  );

  // Next-state logic for the FSM, datapath shift registers and result registers.
  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    sum_d    = sum_q;
    cout_d   = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d    = ovf_q;
`endif
    case (state_q)
      S_RUN: begin
        carry_d  = fa_co;
        sum_sh_d = {fa_s, sum_sh_q[WIDTH-1:1]};
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        cnt_d    = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          // The final sum bit is taken straight from the adder so the result
          // is complete on the same edge that leaves RUN.
          sum_d   = {fa_s, sum_sh_q[WIDTH-1:1]};
          cout_d  = fa_co;
`ifdef SERIAL_ADDER_OVF_EN
          // carry_q is the carry into the MSB at this point.
          ovf_d   = carry_q ^ fa_co;
`endif
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        // IDLE and DONE accept a start identically, enabling back-to-back runs.
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = S_RUN;
          busy_d  = 1'b1;
        end else begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end
      end
    endcase
  end

  // State and output registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_sh_q <= sum_sh_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl at WIDTH = 8 and WIDTH = 16.
module tb_serial_adder_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        start8, cin8, busy8, done8, cout8, ovf8;
  logic [7:0]  a8, b8, sum8;
  logic        start16, cin16, busy16, done16, cout16, ovf16;
  logic [15:0] a16, b16, sum16;

  serial_adder_ctrl #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf8)
`endif
  );

  serial_adder_ctrl #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .a(a16), .b(b16), .cin(cin16),
    .busy(busy16), .done(done16), .sum(sum16), .cout(cout16)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf16)
`endif
  );

`ifndef SERIAL_ADDER_OVF_EN
  assign ovf8  = 1'b0;
  assign ovf16 = 1'b0;
`endif

  int total = 0;
  int bad   = 0;
  int sel   = 0;

  logic        m_busy, m_done, m_cout, m_ovf;
  logic [15:0] m_sum;
  logic [15:0] hold_sum [2];
  logic        hold_co  [2];

  always_comb begin
    if (sel == 0) begin
      m_busy = busy8;  m_done = done8;  m_cout = cout8;  m_ovf = ovf8;
      m_sum  = {8'h00, sum8};
    end else begin
      m_busy = busy16; m_done = done16; m_cout = cout16; m_ovf = ovf16;
      m_sum  = sum16;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic st, input logic [15:0] a, input logic [15:0] b, input logic c);
    if (sel == 0) begin
      start8 = st; a8 = a[7:0]; b8 = b[7:0]; cin8 = c;
    end else begin
      start16 = st; a16 = a; b16 = b; cin16 = c;
    end
  endtask

  // Reference: plain unsigned addition, signed overflow from operand/result signs.
  function automatic logic [17:0] ref_add(input int w, input logic [15:0] a,
                                          input logic [15:0] b, input logic c);
    logic [16:0] am, bm, t;
    logic [15:0] s;
    logic        co, ov;
    am = (w == 8) ? {9'b0, a[7:0]} : {1'b0, a};
    bm = (w == 8) ? {9'b0, b[7:0]} : {1'b0, b};
    t  = am + bm + {16'b0, c};
    s  = (w == 8) ? {8'h00, t[7:0]} : t[15:0];
    co = t[w];
    ov = (a[w-1] == b[w-1]) && (s[w-1] != a[w-1]);
    return {ov, co, s};
  endfunction

  // mode 0: quiet operands; 1: random ignored starts; 2: start with all-ones at E3.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic c,
                        input int mode, input string tag);
    int          w;
    int          n;
    bit          busyok;
    bit          holdok;
    logic [17:0] r;
    w = (sel == 0) ? 8 : 16;
    r = ref_add(w, a, b, c);
    drive(1'b1, a, b, c);
    tick();
    n = 0;
    busyok = 1'b1;
    holdok = 1'b1;
    while (n < w + 4) begin
      if (m_done) break;
      if (!m_busy) busyok = 1'b0;
      if (m_sum !== hold_sum[sel] || m_cout !== hold_co[sel]) holdok = 1'b0;
      if (mode == 1 && n < w - 2)
        drive(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom), 1'($urandom));
      else if (mode == 2)
        drive(n == 2, '1, '1, 1'b1);
      else
        drive(1'b0, 16'($urandom), 16'($urandom), 1'($urandom));
      tick();
      n++;
    end
    chk({tag, " latency"}, n, w);
    chk({tag, " done"}, m_done, 1'b1);
    chk({tag, " busy_run"}, busyok, 1'b1);
    chk({tag, " hold_run"}, holdok, 1'b1);
    chk({tag, " busy_at_done"}, m_busy, 1'b0);
    chk({tag, " sum"}, m_sum, r[15:0]);
    chk({tag, " cout"}, m_cout, r[16]);
`ifdef SERIAL_ADDER_OVF_EN
    chk({tag, " ovf"}, m_ovf, r[17]);
`endif
    hold_sum[sel] = r[15:0];
    hold_co[sel]  = r[16];
    drive(1'b0, 16'($urandom), 16'($urandom), 1'($urandom));
    tick();
    chk({tag, " done_drop"}, m_done, 1'b0);
    chk({tag, " idle_busy"}, m_busy, 1'b0);
    chk({tag, " sum_held"}, m_sum, r[15:0]);
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       c;
    int         mode;
    logic [7:0] s;
    logic       co;
    logic       ov;
  } vec_t;

  vec_t tbl [7];

  initial begin
    tbl[0] = '{8'h5A, 8'h3C, 1'b0, 0, 8'h96, 1'b0, 1'b1};
    tbl[1] = '{8'hFF, 8'h01, 1'b0, 0, 8'h00, 1'b1, 1'b0};
    tbl[2] = '{8'hFF, 8'hFF, 1'b1, 0, 8'hFF, 1'b1, 1'b0};
    tbl[3] = '{8'h10, 8'h20, 1'b0, 2, 8'h30, 1'b0, 1'b0};
    tbl[4] = '{8'h80, 8'h80, 1'b0, 0, 8'h00, 1'b1, 1'b1};
    tbl[5] = '{8'h7F, 8'h00, 1'b1, 1, 8'h80, 1'b0, 1'b1};
    tbl[6] = '{8'h00, 8'h00, 1'b0, 0, 8'h00, 1'b0, 1'b0};

    rst_n = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0;
    hold_sum[0] = '0; hold_sum[1] = '0; hold_co[0] = 1'b0; hold_co[1] = 1'b0;
    #1;
    chk("rst busy", busy8, 1'b0);
    chk("rst done", done8, 1'b0);
    chk("rst sum", sum8, 8'h00);
    chk("rst cout", cout8, 1'b0);
    chk("rst sum16", sum16, 16'h0000);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tick();

    sel = 0;
    for (int i = 0; i < 7; i++) begin
      run_op({8'h00, tbl[i].a}, {8'h00, tbl[i].b}, tbl[i].c, tbl[i].mode, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d tbl_sum", i), sum8, tbl[i].s);
      chk($sformatf("vec%0d tbl_cout", i), cout8, tbl[i].co);
`ifdef SERIAL_ADDER_OVF_EN
      chk($sformatf("vec%0d tbl_ovf", i), ovf8, tbl[i].ov);
`endif
    end

    // Back-to-back: start held high, done every WIDTH+1 cycles.
    begin
      bit prof_ok;
      int ndone;
      prof_ok = 1'b1;
      ndone = 0;
      drive(1'b1, 16'h0001, 16'h0001, 1'b0);
      tick();
      for (int n = 0; n < 27; n++) begin
        if (n > 0) tick();
        if (done8 !== ((n % 9) == 8)) prof_ok = 1'b0;
        if (busy8 !== ((n % 9) != 8)) prof_ok = 1'b0;
        if (done8 === 1'b1) begin
          ndone++;
          chk("b2b sum", sum8, 8'h02);
        end
      end
      chk("b2b profile", prof_ok, 1'b1);
      chk("b2b count", ndone, 3);
      drive(1'b0, 16'h0, 16'h0, 1'b0);
      tick();
      hold_sum[0] = 16'h0002;
      hold_co[0]  = 1'b0;
    end

    // Reset in the middle of a run discards the partial result.
    drive(1'b1, 16'h00AA, 16'h0055, 1'b0);
    tick();
    drive(1'b0, 16'h0, 16'h0, 1'b0);
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    chk("midrst busy", busy8, 1'b0);
    chk("midrst done", done8, 1'b0);
    chk("midrst sum", sum8, 8'h00);
    chk("midrst cout", cout8, 1'b0);
    hold_sum[0] = '0; hold_sum[1] = '0; hold_co[0] = 1'b0; hold_co[1] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    run_op(16'h0001, 16'h0002, 1'b0, 0, "post_rst");
    chk("post_rst sum3", sum8, 8'h03);

    // Randomized sweep at both widths.
    for (int s = 0; s < 2; s++) begin
      sel = s;
      for (int i = 0; i < 600; i++)
        run_op(16'($urandom), 16'($urandom), 1'($urandom),
               ($urandom_range(0, 3) == 0) ? 1 : 0, $sformatf("rnd%0d_%0d", s, i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
